// File: rtl/irq_ctrl_pkg.sv
// Shared types and constants for the TW4 interrupt controller.
// The state enum, mode encoding and channel limit live here so every file uses one definition.
package tw4_irq_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    SERVICE = 1'b1
  } irq_state_t;

  localparam logic IRQ_EDGE  = 1'b0;
  localparam logic IRQ_LEVEL = 1'b1;

  localparam int MAX_CH = 16;

  // A single-channel controller still needs a 1-bit vector port.
  function automatic int vec_width(input int n_ch);
    return (n_ch > 1) ? $clog2(n_ch) : 1;
  endfunction

endpackage

// File: rtl/irq_ctrl_if.sv
// CPU-facing bundle of the interrupt controller: request lines, controls, chain and status.
// master = cpu/board side, slave = the controller itself.
interface irq_ctrl_if #(
    parameter int N_CH = 4
);
    localparam int VEC_W = tw4_irq_pkg::vec_width(N_CH);

    logic [N_CH-1:0]  in;
    logic [N_CH-1:0]  ie;
    logic [N_CH-1:0]  mode;
    logic             ack;
    logic             eoi;
    logic             iei;
    logic             ieo;
    logic             irq;
    logic [VEC_W-1:0] vec;
    logic [N_CH-1:0]  pending;

    modport master (
        output in, ie, mode, ack, eoi, iei,
        input  ieo, irq, vec, pending
    );

    modport slave (
        input  in, ie, mode, ack, eoi, iei,
        output ieo, irq, vec, pending
    );

endinterface

// File: rtl/irq_ctrl_channel.sv
// One interrupt channel: two-flop synchroniser, rise detector and the pending latch.
// Edge-mode pending is sticky until cleared; level-mode pending follows the synchronised line.
module irq_channel
    import tw4_irq_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic in,
    input  logic mode,
    input  logic clr,
    output logic pending
);

    logic s1;
    logic s2;
    logic s2_d;
    logic mode_q;
    logic rise;
    logic pending_nxt;

    // NOTE: state flops use <= so every flop samples the pre-edge value of its source.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1      <= 1'b0;
            s2      <= 1'b0;
            s2_d    <= 1'b0;
            mode_q  <= IRQ_EDGE;
            pending <= 1'b0;
        end else begin
            s1      <= in;
            s2      <= s1;
            s2_d    <= s2;
            mode_q  <= mode;
            pending <= pending_nxt;
        end
    end

    assign rise = s2 & ~s2_d;

    // A new rise beats a simultaneous clear so no edge event is ever lost.
    // Leaving level mode discards the level-derived bit unless a rise is present.
    always_comb begin
        // NOTE: default assignment first so no path through this block infers a latch.
        pending_nxt = pending;
        if (mode == IRQ_LEVEL) begin
            pending_nxt = s2;
        end else if (mode_q == IRQ_LEVEL) begin
            pending_nxt = rise;
        end else begin
            pending_nxt = rise | (pending & ~clr);
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// Parametrised interrupt controller: per-channel latches, fixed priority (channel 0 highest),
// IDLE/SERVICE handshake with the cpu and an iei/ieo daisy chain for cascading.
module irq_ctrl
    import tw4_irq_pkg::*;
#(
    parameter int N_CH = 4
) (
    input  logic       clock,
    input  logic       reset,
    irq_ctrl_if.slave  bus
);

    localparam int VEC_W = vec_width(N_CH);

    logic [N_CH-1:0]  pending;
    logic [N_CH-1:0]  req;
    logic [N_CH-1:0]  clr;
    logic             any_req;
    logic [VEC_W-1:0] win;
    logic [VEC_W-1:0] vec_q;
    logic             irq;
    logic             ieo;
    logic             ack_take;
    irq_state_t       state;
    irq_state_t       state_nxt;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        irq_channel u_ch (
            .clock   (clock),
            .reset   (reset),
            .in      (bus.in[i]),
            .mode    (bus.mode[i]),
            .clr     (clr[i]),
            .pending (pending[i])
        );
    end

    // Disabled channels keep latching; only the request view is masked.
    assign req     = pending & bus.ie;
    assign any_req = |req;

    // Scan downwards so the lowest requesting index is the one left standing.
    always_comb begin
        win = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (req[i]) win = VEC_W'(i);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (ack_take) state_nxt = SERVICE;
            SERVICE: if (bus.eoi)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // While in service the controller neither requests nor lets lower controllers through.
    always_comb begin
        irq      = 1'b0;
        ieo      = 1'b0;
        ack_take = 1'b0;
        if (state == IDLE) begin
            irq      = bus.iei & any_req;
            ieo      = bus.iei & ~any_req;
            ack_take = bus.ack & irq;
        end
    end

    // Level channels are cleared by the device dropping its line, never by ack.
    always_comb begin
        clr = '0;
        for (int i = 0; i < N_CH; i++) begin
            clr[i] = ack_take && (win == VEC_W'(i)) && (bus.mode[i] == IRQ_EDGE);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)        vec_q <= '0;
        else if (ack_take) vec_q <= win;
    end

    assign bus.irq     = irq;
    assign bus.ieo     = ieo;
    assign bus.vec     = vec_q;
    assign bus.pending = pending;

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: vector table, directed corner sequences, cascade/reset,
// then randomized traffic compared against a behavioural model of the controller rules.
module tb_irq_ctrl;

    localparam int N = 4;

    typedef struct {
        logic [N-1:0] in;
        logic [N-1:0] ie;
        logic [N-1:0] mode;
        logic         ack;
        logic         eoi;
        logic         iei;
        logic         exp_irq;
        logic         exp_ieo;
        logic [1:0]   exp_vec;
        logic [N-1:0] exp_pend;
    } row_t;

    logic clock;
    logic reset;
    int   n_checks;
    int   n_fail;

    irq_ctrl_if #(.N_CH(N)) bus_a ();
    irq_ctrl_if #(.N_CH(N)) bus_b ();

    assign bus_b.iei = bus_a.ieo;

    irq_ctrl #(.N_CH(N)) u_dut_a (.clock(clock), .reset(reset), .bus(bus_a));
    irq_ctrl #(.N_CH(N)) u_dut_b (.clock(clock), .reset(reset), .bus(bus_b));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_a(input string name, input logic irq, input logic ieo,
                           input logic [1:0] vec, input logic [N-1:0] pend);
        check({name, ".irq"}, 32'(bus_a.irq), 32'(irq));
        check({name, ".ieo"}, 32'(bus_a.ieo), 32'(ieo));
        check({name, ".vec"}, 32'(bus_a.vec), 32'(vec));
        check({name, ".pending"}, 32'(bus_a.pending), 32'(pend));
    endtask

    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    // Behavioural model: delayed copies of the sampled lines plus a pending set and a service flag.
    logic [N-1:0] m_pend, m_h0, m_h1, m_h2, m_prev_mode;
    bit           m_svc;
    int           m_vec;

    function automatic int lowest(input logic [N-1:0] r);
        for (int i = 0; i < N; i++) if (r[i]) return i;
        return 0;
    endfunction

    task automatic model_reset();
        m_pend = '0; m_h0 = '0; m_h1 = '0; m_h2 = '0; m_prev_mode = '0;
        m_svc = 0; m_vec = 0;
    endtask

    function automatic bit model_irq();
        return !m_svc && bus_a.iei && ((m_pend & bus_a.ie) != '0);
    endfunction

    function automatic bit model_ieo();
        return !m_svc && bus_a.iei && ((m_pend & bus_a.ie) == '0);
    endfunction

    task automatic model_step();
        logic [N-1:0] rise, nxt;
        bit irq;
        int w;
        rise = m_h1 & ~m_h2;
        irq  = model_irq();
        w    = lowest(m_pend & bus_a.ie);
        for (int i = 0; i < N; i++) begin
            if (bus_a.mode[i])       nxt[i] = m_h1[i];
            else if (m_prev_mode[i]) nxt[i] = rise[i];
            else nxt[i] = rise[i] | (m_pend[i] & !(irq && bus_a.ack && w == i));
        end
        if (!m_svc) begin
            if (bus_a.ack && irq) begin
                m_svc = 1;
                m_vec = w;
            end
        end else if (bus_a.eoi) begin
            m_svc = 0;
        end
        m_pend      = nxt;
        m_prev_mode = bus_a.mode;
        m_h2 = m_h1; m_h1 = m_h0; m_h0 = bus_a.in;
    endtask

    row_t tbl[$];

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b0;
        bus_a.in = '0; bus_a.ie = '1; bus_a.mode = '0;
        bus_a.ack = 1'b0; bus_a.eoi = 1'b0; bus_a.iei = 1'b1;
        bus_b.in = '0; bus_b.ie = '1; bus_b.mode = '0;
        bus_b.ack = 1'b0; bus_b.eoi = 1'b0;

        repeat (3) @(posedge clock);
        #1;
        check_a("reset", 1'b0, 1'b1, 2'd0, 4'b0000);
        reset = 1'b1;

        //                in       ie       mode   ack eoi iei  irq ieo vec pend
        tbl.push_back(row_t'{4'b0000, 4'b1111, 4'b0000, 0, 0, 1, 0, 1, 2'd0, 4'b0000});
        tbl.push_back(row_t'{4'b0100, 4'b1111, 4'b0000, 0, 0, 1, 0, 1, 2'd0, 4'b0000});
        tbl.push_back(row_t'{4'b0000, 4'b1111, 4'b0000, 0, 0, 1, 0, 1, 2'd0, 4'b0000});
        tbl.push_back(row_t'{4'b0000, 4'b1111, 4'b0000, 0, 0, 1, 1, 0, 2'd0, 4'b0100});
        tbl.push_back(row_t'{4'b0000, 4'b1111, 4'b0000, 1, 0, 1, 0, 0, 2'd2, 4'b0000});
        tbl.push_back(row_t'{4'b0000, 4'b1111, 4'b0000, 0, 1, 1, 0, 1, 2'd2, 4'b0000});
        tbl.push_back(row_t'{4'b1010, 4'b1111, 4'b0000, 0, 0, 1, 0, 1, 2'd2, 4'b0000});
        tbl.push_back(row_t'{4'b0000, 4'b1111, 4'b0000, 0, 0, 1, 0, 1, 2'd2, 4'b0000});
        tbl.push_back(row_t'{4'b0000, 4'b1111, 4'b0000, 0, 0, 1, 1, 0, 2'd2, 4'b1010});
        tbl.push_back(row_t'{4'b0000, 4'b1111, 4'b0000, 1, 0, 1, 0, 0, 2'd1, 4'b1000});
        tbl.push_back(row_t'{4'b0000, 4'b1111, 4'b0000, 0, 1, 1, 1, 0, 2'd1, 4'b1000});
        tbl.push_back(row_t'{4'b0000, 4'b1111, 4'b0000, 1, 0, 1, 0, 0, 2'd3, 4'b0000});
        tbl.push_back(row_t'{4'b0000, 4'b1111, 4'b0000, 0, 1, 1, 0, 1, 2'd3, 4'b0000});
        tbl.push_back(row_t'{4'b0000, 4'b1111, 4'b0000, 1, 0, 1, 0, 1, 2'd3, 4'b0000});
        tbl.push_back(row_t'{4'b0010, 4'b0000, 4'b0000, 0, 0, 1, 0, 1, 2'd3, 4'b0000});
        tbl.push_back(row_t'{4'b0000, 4'b0000, 4'b0000, 0, 0, 1, 0, 1, 2'd3, 4'b0000});
        tbl.push_back(row_t'{4'b0000, 4'b0000, 4'b0000, 0, 0, 1, 0, 1, 2'd3, 4'b0010});
        tbl.push_back(row_t'{4'b0000, 4'b0010, 4'b0000, 0, 0, 1, 1, 0, 2'd3, 4'b0010});
        tbl.push_back(row_t'{4'b0000, 4'b0010, 4'b0000, 1, 0, 1, 0, 0, 2'd1, 4'b0000});
        tbl.push_back(row_t'{4'b0000, 4'b1111, 4'b0000, 0, 1, 1, 0, 1, 2'd1, 4'b0000});

        foreach (tbl[i]) begin
            bus_a.in = tbl[i].in; bus_a.ie = tbl[i].ie; bus_a.mode = tbl[i].mode;
            bus_a.ack = tbl[i].ack; bus_a.eoi = tbl[i].eoi; bus_a.iei = tbl[i].iei;
            cycle();
            check_a($sformatf("row%0d", i), tbl[i].exp_irq, tbl[i].exp_ieo,
                    tbl[i].exp_vec, tbl[i].exp_pend);
        end
        bus_a.ack = 1'b0; bus_a.eoi = 1'b0;

        // Level mode: ack leaves pending alone, eoi re-raises irq, drop clears after latency.
        bus_a.mode = 4'b0001; bus_a.in = 4'b0001;
        cycle(); cycle();
        check_a("lvl_lat", 1'b0, 1'b1, 2'd1, 4'b0000);
        cycle();
        check_a("lvl_set", 1'b1, 1'b0, 2'd1, 4'b0001);
        bus_a.ack = 1'b1; cycle(); bus_a.ack = 1'b0;
        check_a("lvl_ack", 1'b0, 1'b0, 2'd0, 4'b0001);
        bus_a.eoi = 1'b1; cycle(); bus_a.eoi = 1'b0;
        check_a("lvl_eoi", 1'b1, 1'b0, 2'd0, 4'b0001);
        bus_a.in = 4'b0000;
        cycle(); cycle();
        check_a("lvl_hold", 1'b1, 1'b0, 2'd0, 4'b0001);
        cycle();
        check_a("lvl_drop", 1'b0, 1'b1, 2'd0, 4'b0000);
        bus_a.mode = 4'b0000; cycle();
        check_a("lvl_to_edge", 1'b0, 1'b1, 2'd0, 4'b0000);

        // Rise on the winning channel in the same cycle as its ack keeps pending set.
        bus_a.in = 4'b0010; cycle();
        bus_a.in = 4'b0000; cycle();
        bus_a.in = 4'b0010; cycle();
        check_a("race_set", 1'b1, 1'b0, 2'd0, 4'b0010);
        bus_a.in = 4'b0000; cycle();
        bus_a.ack = 1'b1; cycle(); bus_a.ack = 1'b0;
        check_a("race_ack", 1'b0, 1'b0, 2'd1, 4'b0010);
        bus_a.eoi = 1'b1; cycle(); bus_a.eoi = 1'b0;
        check_a("race_eoi", 1'b1, 1'b0, 2'd1, 4'b0010);
        bus_a.ack = 1'b1; bus_a.eoi = 1'b1; cycle();
        bus_a.ack = 1'b0; bus_a.eoi = 1'b0;
        check_a("ack_eoi", 1'b0, 1'b0, 2'd1, 4'b0000);
        cycle();
        check_a("ack_eoi_hold", 1'b0, 1'b0, 2'd1, 4'b0000);
        bus_a.eoi = 1'b1; cycle(); bus_a.eoi = 1'b0;
        check_a("ack_eoi_done", 1'b0, 1'b1, 2'd1, 4'b0000);

        // iei drops irq at once in IDLE but does not disturb a service in progress.
        bus_a.in = 4'b1000; cycle();
        bus_a.in = 4'b0000; cycle(); cycle();
        check_a("iei_set", 1'b1, 1'b0, 2'd1, 4'b1000);
        bus_a.iei = 1'b0; #1;
        check_a("iei_low", 1'b0, 1'b0, 2'd1, 4'b1000);
        bus_a.iei = 1'b1; #1;
        check_a("iei_high", 1'b1, 1'b0, 2'd1, 4'b1000);
        bus_a.ack = 1'b1; cycle(); bus_a.ack = 1'b0;
        bus_a.iei = 1'b0; cycle();
        check_a("iei_svc", 1'b0, 1'b0, 2'd3, 4'b0000);
        bus_a.eoi = 1'b1; cycle(); bus_a.eoi = 1'b0;
        bus_a.iei = 1'b1; #1;
        check_a("iei_done", 1'b0, 1'b1, 2'd3, 4'b0000);

        // Cascade: A's request blocks B's.
        bus_b.in = 4'b0001; cycle();
        bus_b.in = 4'b0000; cycle(); cycle();
        check("casc_b_irq", 32'(bus_b.irq), 32'd1);
        check("casc_b_pend", 32'(bus_b.pending), 32'h1);
        bus_a.in = 4'b0100; cycle();
        bus_a.in = 4'b0000; cycle(); cycle();
        check_a("casc_a", 1'b1, 1'b0, 2'd3, 4'b0100);
        check("casc_b_blocked", 32'(bus_b.irq), 32'd0);
        check("casc_b_ieo", 32'(bus_b.ieo), 32'd0);
        bus_a.ack = 1'b1; cycle(); bus_a.ack = 1'b0;
        check_a("casc_a_svc", 1'b0, 1'b0, 2'd2, 4'b0000);
        check("casc_b_svc", 32'(bus_b.irq), 32'd0);

        // Reset mid-service clears everything asynchronously.
        #2; reset = 1'b0; #1;
        check_a("rst_svc", 1'b0, 1'b1, 2'd0, 4'b0000);
        check("rst_b_pend", 32'(bus_b.pending), 32'h0);
        check("rst_b_ieo", 32'(bus_b.ieo), 32'd1);
        cycle();
        reset = 1'b1;
        model_reset();

        for (int t = 0; t < 3000; t++) begin
            bus_a.in = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) bus_a.ie = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 15) == 0) bus_a.mode = 4'($urandom_range(0, 15));
            bus_a.ack = ($urandom_range(0, 3) == 0);
            bus_a.eoi = ($urandom_range(0, 3) == 0);
            bus_a.iei = ($urandom_range(0, 7) != 0);
            model_step();
            cycle();
            check($sformatf("rnd%0d.irq", t), 32'(bus_a.irq), 32'(model_irq()));
            check($sformatf("rnd%0d.ieo", t), 32'(bus_a.ieo), 32'(model_ieo()));
            check($sformatf("rnd%0d.vec", t), 32'(bus_a.vec), 32'(m_vec));
            check($sformatf("rnd%0d.pending", t), 32'(bus_a.pending), 32'(m_pend));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Parametrised interrupt controller; successor to the fixed four-button daisy chain around the TW4 cpu.
- Gathers N_CH external request lines, synchronises them, latches edge or level requests and applies per-channel enable.
- Resolves a fixed priority (channel 0 highest) and presents one irq plus a latched vector to the cpu.
- Exposes iei/ieo so several controllers cascade in priority order.

Parameters:
N_CH, 4, number of interrupt channels (1..16)
VEC_W, derived localparam = max(1, clog2(N_CH)), vector width (not overridable)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low; 0 holds the block in reset
in  input  N_CH  raw asynchronous request lines, one per channel
ie  input  N_CH  per-channel enable from cpu; 1 = enabled
mode  input  N_CH  per-channel mode; 0 = rising edge, 1 = level-high
ack  input  1  cpu interrupt acknowledge, single-cycle pulse
eoi  input  1  cpu end-of-interrupt, single-cycle pulse
iei  input  1  priority chain in; tie 1 on the highest-priority controller
ieo  output  1  priority chain out to the next lower controller
irq  output  1  interrupt request to cpu
vec  output  VEC_W  index of the acknowledged channel
pending  output  N_CH  latched request bits, for cpu status reads

Behaviour:
- Reset (reset=0, async): all sync flops, pending, vec and state cleared; state=IDLE; irq=0; ieo=iei.
- Synchroniser: per channel s1<=in, s2<=s1, s2_d<=s2.
- Edge mode: rise = s2 & ~s2_d; pending set at the clock edge where rise=1. A pulse on in sampled at edge k makes pending=1 after edge k+2.
- Edge mode: pending stays set until cleared by ack. A new rise in the same cycle as the clearing ack wins, so pending stays 1 and no event is lost.
- Level mode: pending tracks s2 (two-cycle latency) and is not cleared by ack; the device must drop in.
- A mode change takes effect next cycle. A channel switched to edge mode starts with pending=0 unless rise=1.
- req = pending & ie, combinational. Disabled channels still latch pending; setting ie later raises irq at once.
- win = lowest index i with req[i]=1, combinational priority encoder.
- FSM states: IDLE, SERVICE.
- IDLE: irq = iei & |req (combinational).
- IDLE and ack=1 and irq=1: vec<=win; if mode[win]=0, clear pending[win]; next state SERVICE.
- IDLE and ack=1 and irq=0: ignored, no state change.
- IDLE and eoi=1: ignored. If ack and eoi arrive together in IDLE, ack is processed and eoi dropped.
- SERVICE: irq=0; vec held stable; new requests keep latching.
- SERVICE and eoi=1: next state IDLE. irq may reassert next cycle if req is non-zero.
- SERVICE and ack=1: ignored.
- ieo = iei & (state==IDLE) & ~|req, combinational. A controller with a request or in service blocks everything below it.
- iei falling while IDLE drops irq combinationally. iei falling in SERVICE has no effect; service completes normally.
- vec holds its last value in IDLE. Software reads vec only after ack.
- Reset asserted mid-SERVICE aborts service; state returns to IDLE and all pending are lost.

Decomposition:
- Package tw4_irq_pkg holds:
  - irq_state_t enum {IDLE, SERVICE}
  - mode encoding constants IRQ_EDGE=0, IRQ_LEVEL=1
  - MAX_CH=16
- Sub-module irq_channel, one per channel via generate:
  - contains s1/s2/s2_d, rise detection and the pending flop
  - inputs: clock, reset, in, mode, clr
  - output: pending
- irq_ctrl holds the priority encoder, FSM, vec register and chain logic.

Test Plan:
- Edge latency, vec and ack clear: reset release, ie=4'b1111, mode=0, pulse in[2] for one cycle at edge k -> pending=4'b0100 after edge k+2, irq=1. Then ack -> vec=2, pending=0, irq=0. Then eoi -> IDLE, irq stays 0.
- Priority and ieo: in[3] and in[1] rise together, ie=4'b1111 -> irq=1, ieo=0. First ack gives vec=1; after eoi irq=1 again; second ack gives vec=3.
- Level mode: mode[0]=1, hold in[0]=1 -> irq. ack gives vec=0 and pending[0] stays 1; eoi with in[0] still high -> irq reasserts next cycle. Drop in[0] -> pending[0]=0 two cycles later.
- Masking: ie=0 with in[1] pulsed -> pending[1]=1, irq=0, ieo=iei. Set ie[1]=1 -> irq=1 the same cycle.
- Ack races: ack with irq=0 -> no state change. New rise on the winning channel in the same cycle as ack -> vec=win and pending stays 1. ack+eoi together in IDLE -> SERVICE.
- Cascade and reset: two instances, A.ieo -> B.iei; A requests -> B.irq forced 0 despite B request. Reset pulsed low during SERVICE -> irq=0, pending=0, vec=0 immediately; ieo=iei.
